// File: rtl/instr_pack_if.sv
// Request/response bundle for instr_pack: field-level request in, packed word out.
// master drives requests and consumes words; slave is the encoder.
interface instr_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  immsrc;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   modport master (
      output in_valid, immsrc, opcode, funct3, rd, rs1, rs2, imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err
   );

   modport slave (
      input  in_valid, immsrc, opcode, funct3, rd, rs1, rs2, imm, out_ready,
      output in_ready, out_valid, out_instr, out_err
   );
endinterface

// File: rtl/instr_pack.sv
// Streaming RISC-V instruction encoder (I/S/B/J) with a small output FIFO and range-error flag.
// Optional INSTR_PACK_STATS_EN adds saturating popped-word / popped-error counters.
module instr_pack #(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   instr_pack_if.slave  bus
`ifdef INSTR_PACK_STATS_EN
   ,
   output logic [15:0]  stat_words,
   output logic [15:0]  stat_errs
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic signed [31:0] imm_s;
   logic [31:0]        packed_instr;
   logic               range_err;

   logic [32:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   assign imm_s = $signed(bus.imm);

   always_comb begin
      packed_instr = '0;
      range_err    = 1'b0;
      unique case (bus.immsrc)
         2'b00: begin
            packed_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            range_err    = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         2'b01: begin
            packed_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                            bus.opcode};
            range_err    = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         2'b10: begin
            packed_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:1], bus.imm[11], bus.opcode};
            range_err    = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.imm[0];
         end
         2'b11: begin
            packed_instr = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd,
                            bus.opcode};
            range_err    = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.imm[0];
         end
         default: ;
      endcase
   end

   // in_ready depends only on registered occupancy, so no out_ready->in_ready path exists.
   assign bus.in_ready  = (count_q != CW'(DEPTH));
   assign bus.out_valid = (count_q != '0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q][31:0] : '0;
   assign bus.out_err   = bus.out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted as occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {range_err, packed_instr};
      end
   end

`ifdef INSTR_PACK_STATS_EN
   logic [15:0] stat_words_q, stat_errs_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_words_q <= '0;
         stat_errs_q  <= '0;
      end else if (pop) begin
         if (stat_words_q != 16'hFFFF) begin
            stat_words_q <= stat_words_q + 16'd1;
         end
         if (bus.out_err && (stat_errs_q != 16'hFFFF)) begin
            stat_errs_q <= stat_errs_q + 16'd1;
         end
      end
   end

   assign stat_words = stat_words_q;
   assign stat_errs  = stat_errs_q;
`endif

endmodule

// File: tb/tb_instr_pack.sv
// Scoreboard bench for instr_pack: driver pushes expected words, a monitor pops and compares.
// Directed vectors cover every format, range boundaries, backpressure and mid-stream reset.
module tb_instr_pack;

   typedef struct packed {
      logic [1:0]  src;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   localparam int NVEC = 15;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   n_pop;
   int   n_errpop;
   exp_t sb[$];
   vec_t vecs [NVEC];

   instr_pack_if bus ();

`ifdef INSTR_PACK_STATS_EN
   logic [15:0] stat_words;
   logic [15:0] stat_errs;
`endif

   instr_pack #(
      .DEPTH(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus)
`ifdef INSTR_PACK_STATS_EN
      ,
      .stat_words (stat_words),
      .stat_errs  (stat_errs)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input vec_t v);
      @(negedge clk);
      bus.immsrc   = v.src;
      bus.opcode   = v.op;
      bus.funct3   = v.f3;
      bus.rd       = v.rd;
      bus.rs1      = v.rs1;
      bus.rs2      = v.rs2;
      bus.imm      = v.imm;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) break;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end else begin
         @(posedge clk);
         sb.push_back('{instr: v.exp_instr, err: v.exp_err});
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compare every handshake against the scoreboard, and check hold stability.
   initial begin : monitor
      logic        stalled;
      logic [32:0] held;
      exp_t        e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled = 1'b0;
         end else begin
            if (stalled && bus.out_valid) begin
               check("hold_stable", {31'd0, bus.out_err}, {31'd0, held[32]});
               check("hold_stable_instr", bus.out_instr, held[31:0]);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_word: got %h expected none", bus.out_instr);
               end else begin
                  e = sb.pop_front();
                  check("out_instr", bus.out_instr, e.instr);
                  check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
                  n_pop++;
                  if (e.err) n_errpop++;
               end
               stalled = 1'b0;
            end else if (bus.out_valid) begin
               stalled = 1'b1;
               held    = {bus.out_err, bus.out_instr};
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      n_pop    = 0;
      n_errpop = 0;
      //          src    op     f3    rd    rs1   rs2   imm           instr         err
      vecs[0]  = '{2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
      vecs[1]  = '{2'b01, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 32'h00000008, 32'h0021A423, 1'b0};
      vecs[2]  = '{2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
      vecs[3]  = '{2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0};
      vecs[4]  = '{2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00000003, 32'h00000163, 1'b1};
      vecs[5]  = '{2'b00, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00000800, 32'h80000013, 1'b1};
      vecs[6]  = '{2'b00, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'h00000064, 32'h06430293, 1'b0};
      vecs[7]  = '{2'b00, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000013, 1'b0};
      vecs[8]  = '{2'b01, 7'h23, 3'd0, 5'd0, 5'd0, 5'd0, 32'h000007FF, 32'h7E000FA3, 1'b0};
      vecs[9]  = '{2'b01, 7'h23, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFF7FF, 32'h7E000FA3, 1'b1};
      vecs[10] = '{2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00000FFE, 32'h7E000FE3, 1'b0};
      vecs[11] = '{2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00001000, 32'h80000063, 1'b1};
      vecs[12] = '{2'b11, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 32'h8000006F, 1'b0};
      vecs[13] = '{2'b11, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00100000, 32'h8000006F, 1'b1};
      vecs[14] = '{2'b11, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00000001, 32'h0000006F, 1'b1};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.immsrc    = '0;
      bus.opcode    = '0;
      bus.funct3    = '0;
      bus.rd        = '0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.imm       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_instr", bus.out_instr, 32'd0);
      check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      for (int i = 0; i < NVEC; i++) begin
         send(vecs[i]);
         if (i == 0) check("latency_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      drain();

`ifdef INSTR_PACK_STATS_EN
      check("stat_words", {16'd0, stat_words}, 32'(n_pop));
      check("stat_errs", {16'd0, stat_errs}, 32'(n_errpop));
`endif

      // Backpressure: two words fill DEPTH=2, the third must wait for the release.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send(vecs[1]);
      send(vecs[2]);
      @(negedge clk);
      check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
      fork
         send(vecs[3]);
         begin
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset mid-stream: queued words are discarded immediately.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send(vecs[0]);
      send(vecs[6]);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_out_instr", bus.out_instr, 32'd0);
      sb.delete();
      @(negedge clk);
      #2 reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef INSTR_PACK_STATS_EN
      check("post_rst_stat_words", {16'd0, stat_words}, 32'd0);
`endif
      send(vecs[7]);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_pack.md
Name: instr_pack

Overview:
- Streaming RISC-V instruction encoder: field-level inputs (opcode, registers, funct3, signed immediate, immsrc) -> packed 32-bit instruction word.
- Inverse of the core's immediate-extend stage. Uses the same immsrc encoding: 00 I, 01 S, 10 B, 11 J.
- Sits between the debug/program-buffer injector and the instruction-memory write port.
- Valid/ready handshake on both sides; small output FIFO; per-word range-error flag.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- immsrc  in  2  format: 00 I, 01 S, 10 B, 11 J
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]; ignored for J
- rd  in  5  instr[11:7]; ignored for S/B
- rs1  in  5  instr[19:15]; ignored for J
- rs2  in  5  instr[24:20]; used for S/B only
- imm  in  32  signed immediate value (byte offset for B/J)
- out_valid  out  1  packed word available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  packed instruction
- out_err  out  1  immediate out of range or misaligned for this word

Behaviour:
- Reset (async, active-high):
  - FIFO emptied.
  - out_valid=0, out_instr=0, out_err=0.
  - in_ready=1 after reset deasserts.
  - An in-flight word is discarded.
- Packing is combinational on the inputs. The result is written into the FIFO on accept.
  - Latency: accept at edge N -> out_valid=1 after edge N (registered output, 1 cycle).
- Packing rules:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range check, out_err=1 when:
  - I/S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094] or imm[0]=1.
  - J: imm not in [-1048576, 1048574] or imm[0]=1.
- On error the word is still emitted with the truncated bits, and out_err=1 travels with that word.
- Round-trip property: for any in-range input, extending out_instr[31:7] with the same immsrc returns imm exactly.
- FIFO:
  - in_ready = !full.
  - Simultaneous push and pop when full is NOT allowed; in_ready stays 0 while full. No combinational ready path from out_ready to in_ready.
  - Simultaneous push and pop when 0<count<DEPTH leaves count unchanged.
  - Push on empty: the word appears next cycle. No bypass in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
- out_instr/out_err are held stable while out_valid & !out_ready.
- Beats complete in order, never dropped, never duplicated.

Optional Feature:
- Macro INSTR_PACK_STATS_EN.
- When defined, two extra output ports are present:
  - stat_words (16b): count of words popped.
  - stat_errs (16b): count of popped words with out_err=1.
- Both counters reset to 0, saturate at 0xFFFF, and increment only on an output handshake.
- When undefined, the ports and logic are absent. Core behaviour is identical either way.

Test Plan:
- I addi x1,x0,-1: immsrc=00, opcode=0x13, funct3=0, rd=1, rs1=0, imm=-1 -> out_instr=0xFFF00093, out_err=0, one cycle after accept.
- S sw x2,8(x3): immsrc=01, opcode=0x23, funct3=2, rs1=3, rs2=2, imm=8 -> 0x0021A423.
- B beq x0,x0,-4: immsrc=10, opcode=0x63, imm=-4 -> 0xFE000EE3.
- J jal x1,2048: immsrc=11, opcode=0x6F, rd=1, imm=2048 -> 0x001000EF.
- Errors:
  - B with imm=3 -> out_err=1.
  - I with imm=2048 -> out_err=1, imm field 0x800.
  - Next legal word -> out_err=0.
  - With STATS: stat_errs=2.
- Backpressure and reset:
  - Hold out_ready=0, push 3 words (DEPTH=2) -> in_ready=0 after 2 accepts.
  - Release -> words pop in order with no loss.
  - Assert reset mid-stream -> out_valid=0 immediately; FIFO empty afterwards.
